queue_burst_reader: RTL and testbench

//  Drain-side controller for the parameterized queue. On start, pops up to burst_len

---
 rtl/qread_pkg.sv | 17 +
 rtl/qread_skid.sv | 64 ++++++
 rtl/queue_burst_reader.sv | 128 ++++++++++++
 tb/tb_queue_burst_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qread_pkg.sv
// Shared types and constants for the queue burst reader.
// Optional statistics are enabled by defining QREAD_STATS_EN.
package qread_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } qread_state_t;

  // The skid holds the words still on their way to the stream. Two entries
  // cover the queue's one-cycle read latency at one word per cycle.
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/qread_skid.sv
// Two-entry FIFO of {last, data}. Entry 0 is the head and drives the outputs
// directly from a register. A push into a full skid is prevented upstream by
// the reader's dequeue credit.
module qread_skid
  import qread_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH:0] mem [SKID_DEPTH];
  logic [WIDTH:0] push_entry;
  logic           do_pop;

  assign push_entry = {push_last, push_data};
  assign do_pop     = pop && (occ != '0);

  // Shift-style storage: pops move entry 1 to the head, pushes fill the first free slot.
  // NOTE: state and storage use non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= '0;
      // NOTE: the entries are reset too, because the head entry drives the stream data port, which must read 0 out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (occ == '0) mem[0] <= push_entry;
          else           mem[1] <= push_entry;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          mem[0] <= mem[1];
          occ    <= occ - OCC_W'(1);
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            mem[0] <= push_entry;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (occ != '0);
  assign data  = mem[0][WIDTH-1:0];
  assign last  = mem[0][WIDTH];

endmodule

// File: rtl/queue_burst_reader.sv
// Drain-side burst controller for the parameterized queue. Pops up to
// burst_len words, absorbs the queue's one-cycle read latency in a two-entry
// skid and delivers the words on a valid/ready stream tagged with m_last.
// Define QREAD_STATS_EN to add the word_count and stall_count outputs.
module queue_burst_reader
  import qread_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             q_deq,
  input  logic             q_empty,
  input  logic [WIDTH-1:0] q_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef QREAD_STATS_EN
  ,
  output logic [31:0]      word_count,
  output logic [31:0]      stall_count
`endif
);

  qread_state_t     state;
  logic [LEN_W-1:0] remaining;
  logic             in_flight;
  logic             in_flight_last;
  logic             credit;
  logic             skid_pop;
  logic [OCC_W-1:0] skid_occ;

  // A word accepted downstream this cycle frees its slot for a same-cycle dequeue,
  // which keeps a full-rate stream going with only two slots.
  assign skid_pop = m_valid && m_ready;
  assign credit   = (32'(skid_occ) + 32'(in_flight)) < (32'd2 + 32'(skid_pop));
  assign q_deq    = (state == READ) && !q_empty && (remaining != '0) && credit;

  // Burst sequencing; busy and done are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (burst_len != '0) begin
              remaining <= burst_len;
              state     <= READ;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (q_deq) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish once nothing is in flight and the last buffered word leaves.
          if (!in_flight && ((skid_occ == '0) || ((skid_occ == OCC_W'(1)) && skid_pop))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Track the dequeue whose data arrives next cycle and whether it ends the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight      <= q_deq;
      in_flight_last <= q_deq && (remaining == LEN_W'(1));
    end
  end

  // The returning queue word is always captured: credit guarantees a free slot.
  qread_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (q_data),
    .push_last (in_flight_last),
    .pop       (skid_pop),
    .valid     (m_valid),
    .data      (m_data),
    .last      (m_last),
    .occ       (skid_occ)
  );

`ifdef QREAD_STATS_EN
  // Free-running transfer and underrun counters, wrapping modulo 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count  <= '0;
      stall_count <= '0;
    end else begin
      if (skid_pop) word_count <= word_count + 32'd1;
      if ((state == READ) && q_empty) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_burst_reader.sv
// Self-checking bench for queue_burst_reader: a behavioural queue with a
// registered read port, a stream monitor, a table of burst vectors and
// hand-written sequences for latency, underrun, zero length, restart and reset.
module tb_queue_burst_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] burst_len;
  logic       busy;
  logic       done;
  logic       q_deq;
  logic       q_empty;
  logic [7:0] q_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
`ifdef QREAD_STATS_EN
  logic [31:0] word_count;
  logic [31:0] stall_count;
`endif

  queue_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .q_deq     (q_deq),
    .q_empty   (q_empty),
    .q_data    (q_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef QREAD_STATS_EN
    ,
    .word_count  (word_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural queue: data_out is registered and valid the cycle after a dequeue.
  logic       push_en;
  logic [7:0] push_val;
  logic [7:0] qmem [0:63];
  logic [5:0] wr_ptr, rd_ptr;

  assign q_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_data <= '0;
    end else begin
      if (q_deq) begin
        q_data <= qmem[rd_ptr];
        rd_ptr <= rd_ptr + 6'd1;
      end
      if (push_en) begin
        qmem[wr_ptr] <= push_val;
        wr_ptr       <= wr_ptr + 6'd1;
      end
    end
  end

  // Stream monitor sampled mid-cycle: records transfers and protocol violations.
  logic [7:0] rx_data [0:63];
  logic       rx_last [0:63];
  int         rx_n, done_n, deq_n;
  int         viol_empty, viol_out, viol_stable;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (rst) begin
      rx_n        <= 0;
      done_n      <= 0;
      deq_n       <= 0;
      viol_empty  <= 0;
      viol_out    <= 0;
      viol_stable <= 0;
      prev_stall  <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        rx_data[rx_n] <= m_data;
        rx_last[rx_n] <= m_last;
        rx_n          <= rx_n + 1;
      end
      if (done) done_n <= done_n + 1;
      if (q_deq) deq_n <= deq_n + 1;
      if (q_deq && q_empty) viol_empty <= viol_empty + 1;
      if ((deq_n + int'(q_deq)) - (rx_n + int'(m_valid && m_ready)) > 2) viol_out <= viol_out + 1;
      if (prev_stall && (!m_valid || (m_data != prev_data) || (m_last != prev_last)))
        viol_stable <= viol_stable + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    start    = 1'b0;
    burst_len = '0;
    push_en  = 1'b0;
    push_val = '0;
    m_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic preload(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push_en  = 1'b1;
      push_val = base + 8'(i);
      tick();
    end
    push_en = 1'b0;
  endtask

  // Start a burst and run until busy drops; mode 0 = always ready, mode 1 = ready 1,0,0,...
  task automatic run_burst(input logic [7:0] len, input int mode, input string tag);
    start     = 1'b1;
    burst_len = len;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      m_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      tick();
      if (!busy) break;
    end
    check({tag, "_idle_after_burst"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    int         preload;
    logic [7:0] base;
    logic [7:0] len;
    int         mode;
    int         exp_words;
    logic [7:0] exp_last_data;
    int         exp_left;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{preload: 5, base: 8'h11, len: 8'd4, mode: 0, exp_words: 4, exp_last_data: 8'h14, exp_left: 1};
    vecs[1] = '{preload: 3, base: 8'h30, len: 8'd3, mode: 1, exp_words: 3, exp_last_data: 8'h32, exp_left: 0};
    vecs[2] = '{preload: 6, base: 8'h50, len: 8'd6, mode: 1, exp_words: 6, exp_last_data: 8'h55, exp_left: 0};
    vecs[3] = '{preload: 1, base: 8'hF0, len: 8'd1, mode: 0, exp_words: 1, exp_last_data: 8'hF0, exp_left: 0};
    vecs[4] = '{preload: 8, base: 8'h80, len: 8'd2, mode: 1, exp_words: 2, exp_last_data: 8'h81, exp_left: 6};

    do_reset();

    // Reset state.
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_q_deq",   32'(q_deq),   32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last",  32'(m_last),  32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);

    // Table-driven bursts.
    for (int r = 0; r < 5; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      do_reset();
      preload(vecs[r].preload, vecs[r].base);
      run_burst(vecs[r].len, vecs[r].mode, tag);
      check({tag, "_words"}, 32'(rx_n), 32'(vecs[r].exp_words));
      for (int i = 0; i < vecs[r].exp_words && i < rx_n; i++) begin
        check($sformatf("%s_data%0d", tag, i), 32'(rx_data[i]), 32'(vecs[r].base + 8'(i)));
        check($sformatf("%s_last%0d", tag, i), 32'(rx_last[i]), 32'(i == vecs[r].exp_words - 1));
      end
      if (rx_n >= vecs[r].exp_words)
        check({tag, "_last_word"}, 32'(rx_data[vecs[r].exp_words - 1]), 32'(vecs[r].exp_last_data));
      check({tag, "_done_pulses"},  32'(done_n), 32'd1);
      check({tag, "_left_queued"},  32'(wr_ptr - rd_ptr), 32'(vecs[r].exp_left));
      check({tag, "_deq_on_empty"}, 32'(viol_empty), 32'd0);
      check({tag, "_outstanding"},  32'(viol_out), 32'd0);
      check({tag, "_stall_stable"}, 32'(viol_stable), 32'd0);
    end

    // Exact latency: first dequeue the cycle after start, words on consecutive cycles.
    do_reset();
    preload(5, 8'h11);
    m_ready = 1'b1;
    check("lat_no_deq_before_start", 32'(q_deq), 32'd0);
    start     = 1'b1;
    burst_len = 8'd4;
    tick();
    start = 1'b0;
    check("lat_busy_after_start", 32'(busy), 32'd1);
    check("lat_first_deq", 32'(q_deq), 32'd1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat_valid%0d", i), 32'(m_valid), 32'd1);
      check($sformatf("lat_data%0d", i),  32'(m_data),  32'(8'h11 + 8'(i)));
      check($sformatf("lat_last%0d", i),  32'(m_last),  32'(i == 3));
      tick();
    end
    check("lat_done_high", 32'(done), 32'd1);
    tick();
    check("lat_done_low", 32'(done), 32'd0);
    check("lat_busy_low", 32'(busy), 32'd0);
    check("lat_left_one", 32'(wr_ptr - rd_ptr), 32'd1);

    // Underrun: empty queue, words trickle in at cycles 10 and 20.
    do_reset();
    start     = 1'b1;
    burst_len = 8'd2;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      push_en  = (c == 10) || (c == 20);
      push_val = (c == 10) ? 8'hA0 : 8'hA1;
      tick();
    end
    push_en = 1'b0;
    check("und_words", 32'(rx_n), 32'd2);
    check("und_data0", 32'(rx_data[0]), 32'hA0);
    check("und_last0", 32'(rx_last[0]), 32'd0);
    check("und_data1", 32'(rx_data[1]), 32'hA1);
    check("und_last1", 32'(rx_last[1]), 32'd1);
    check("und_deq_on_empty", 32'(viol_empty), 32'd0);
    check("und_done_pulses", 32'(done_n), 32'd1);
    check("und_idle", 32'(busy), 32'd0);
`ifdef QREAD_STATS_EN
    check("und_word_count",  word_count,  32'd2);
    check("und_stall_count", stall_count, 32'd19);
`endif

    // Zero-length burst: no dequeue, done the cycle after start is accepted.
    do_reset();
    preload(2, 8'h40);
    start     = 1'b1;
    burst_len = 8'd0;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd1);
    tick();
    check("zero_done_low", 32'(done), 32'd0);
    check("zero_busy_low", 32'(busy), 32'd0);
    repeat (3) tick();
    check("zero_no_deq", 32'(deq_n), 32'd0);
    check("zero_no_words", 32'(rx_n), 32'd0);
    check("zero_done_pulses", 32'(done_n), 32'd1);

    // start while busy is ignored.
    do_reset();
    preload(6, 8'h60);
    start     = 1'b1;
    burst_len = 8'd3;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start     = 1'b1;
    burst_len = 8'd9;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50 && busy; c++) tick();
    repeat (3) tick();
    check("restart_idle", 32'(busy), 32'd0);
    check("restart_words", 32'(rx_n), 32'd3);
    check("restart_last_data", 32'(rx_data[2]), 32'h62);
    check("restart_last_flag", 32'(rx_last[2]), 32'd1);
    check("restart_left", 32'(wr_ptr - rd_ptr), 32'd3);
    check("restart_done_pulses", 32'(done_n), 32'd1);

    // Reset in DRAIN with a word waiting, then a fresh burst.
    do_reset();
    preload(4, 8'h70);
    start     = 1'b1;
    burst_len = 8'd3;
    m_ready   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    m_ready = 1'b0;
    check("drain_busy",  32'(busy),    32'd1);
    check("drain_valid", 32'(m_valid), 32'd1);
    check("drain_data",  32'(m_data),  32'h71);
`ifdef QREAD_STATS_EN
    check("drain_word_count", word_count, 32'd1);
`endif
    rst = 1'b1;
    #1;
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_done",    32'(done),    32'd0);
    check("midrst_q_deq",   32'(q_deq),   32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_last",  32'(m_last),  32'd0);
    check("midrst_m_data",  32'(m_data),  32'd0);
`ifdef QREAD_STATS_EN
    check("midrst_word_count", word_count, 32'd0);
`endif
    do_reset();
    preload(2, 8'h90);
    run_burst(8'd2, 0, "post_rst");
    check("post_rst_words", 32'(rx_n), 32'd2);
    check("post_rst_data0", 32'(rx_data[0]), 32'h90);
    check("post_rst_data1", 32'(rx_data[1]), 32'h91);
    check("post_rst_last1", 32'(rx_last[1]), 32'd1);
    check("post_rst_done_pulses", 32'(done_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
